hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Central pipeline hazard and stall controller for the 5-stage MIPS pipeline.
- Watches the IF/ID instruction, the ID/EX load destination, branch resolution in EX, and the MEM-stage data-memory handshake.
- Drives the write-enable and flush controls of PC, IF/ID and ID/EX, plus a global freeze for EX/MEM and MEM/WB.
- Provides a saturating stall-cycle counter and a sticky memory-timeout error.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID is flushed after a taken branch. Range 1..7. The first cycle also flushes ID/EX.
- MEM_TIMEOUT, 255: consecutive memory-wait cycles before Timeout_Err sets. Range 1..65535.
- CNT_W, 16: width of the StallCycles counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; 0 = reset
- IFID_Rs  in  5  rs field of the instruction in ID
- IFID_Rt  in  5  rt field of the instruction in ID
- IFID_UsesRt  in  1  ID instruction reads rt as a source
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_Rt  in  5  load destination register in EX
- Branch_Taken  in  1  branch resolved taken in EX this cycle
- DMem_Req  in  1  MEM stage is accessing data memory
- DMem_Ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC load enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  clear IF/ID to NOP
- IDEX_Write  out  1  ID/EX load enable
- IDEX_Flush  out  1  clear ID/EX (bubble)
- Pipe_Freeze  out  1  hold EX/MEM and MEM/WB
- StallCycles  out  CNT_W  saturating count of cycles with PCWrite=0
- Timeout_Err  out  1  sticky memory-timeout flag

Behaviour:
- States: RUN, FLUSH, MEM_WAIT.
- Control outputs are combinational from state and inputs, so they apply in the same cycle. Counters and flags are registered.
- Defaults (no hazard): PCWrite=1, IFID_Write=1, IDEX_Write=1, all flushes 0, Pipe_Freeze=0.
- Reset (reset=0 at a clock edge):
  - state=RUN, flush counter=0, wait counter=0, StallCycles=0, Timeout_Err=0.
  - While reset=0: PCWrite=0, IFID_Flush=1, IDEX_Flush=1, Pipe_Freeze=0, IFID_Write=1, IDEX_Write=1.
  - Reset mid-FLUSH or mid-MEM_WAIT abandons the state immediately.
- Priority, highest first: memory wait, taken branch, load-use.
- Memory wait: DMem_Req=1 and DMem_Ready=0.
  - Outputs: PCWrite=0, IFID_Write=0, IDEX_Write=0, Pipe_Freeze=1, no flushes.
  - Next state is MEM_WAIT. The wait counter increments each waiting cycle.
  - When the counter reaches MEM_TIMEOUT, Timeout_Err sets. It stays set until reset; freezing continues.
  - DMem_Ready=1 in MEM_WAIT releases the freeze that cycle, clears the wait counter, and returns to RUN.
  - A branch asserted during the freeze is held in EX and is serviced on the release cycle.
- Taken branch (RUN, no memory wait):
  - IFID_Flush=1, IDEX_Flush=1, PCWrite=1 (PC loads the target).
  - If FLUSH_CYCLES>1, go to FLUSH with the counter = FLUSH_CYCLES-1.
- FLUSH state:
  - Outputs: IFID_Flush=1, IDEX_Flush=0, PCWrite=1.
  - Counter decrements each cycle; return to RUN when it reaches 0.
  - Load-use detection is suppressed in FLUSH.
  - A memory wait in FLUSH freezes and holds the counter.
  - Branch_Taken in FLUSH reloads the counter and asserts IDEX_Flush.
- Load-use (RUN only), condition:
  - IDEX_MemRead=1, IDEX_Rt!=0, and (IDEX_Rt==IFID_Rs, or IFID_UsesRt=1 with IDEX_Rt==IFID_Rt).
  - Outputs: PCWrite=0, IFID_Write=0, IDEX_Flush=1 for exactly one cycle. State stays RUN.
  - Taken branch in the same cycle wins; no stall.
- StallCycles:
  - Increments on each non-reset cycle with PCWrite=0.
  - Saturates at all-ones; no wrap.

Decomposition:
- Shared package holds:
  - state enum (RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2)
  - REG_W=5
  - ZERO_REG=5'd0
- One natural sub-module: sat_counter, a parameterised width counter with increment enable and synchronous active-low clear. It is used for StallCycles.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> one cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1; the next cycle returns to defaults; StallCycles=1.
- Register $0: same as above but IDEX_Rt=0 -> no stall. IFID_Rt=8 with IFID_UsesRt=0 -> no stall.
- Branch flush with FLUSH_CYCLES=3, Branch_Taken pulse -> cycle 0: IFID_Flush=1 and IDEX_Flush=1; cycles 1-2: IFID_Flush only; then RUN.
- Branch and load-use in the same cycle -> flush only, PCWrite=1, StallCycles unchanged.
- Memory wait with MEM_TIMEOUT=4: DMem_Req=1 with Ready held low for 6 cycles -> Pipe_Freeze=1 throughout; Timeout_Err=1 from the 4th cycle. Ready=1 -> release that cycle; Timeout_Err stays 1.
- Reset mid-MEM_WAIT: reset=0 for one edge -> state RUN, StallCycles=0, Timeout_Err=0; both flushes high while reset=0.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// ============================================================================
// Module   : hazard_control_unit_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hcu_state_t;

    localparam int              REG_W    = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Width-parameterised saturating up-counter with synchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module   : hazard_control_unit
// Brief    : Stall/flush/freeze controller for the 5-stage MIPS pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic             Branch_Taken,
    input  logic             DMem_Req,
    input  logic             DMem_Ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Flush,
    output logic             Pipe_Freeze,
    output logic [CNT_W-1:0] StallCycles,
    output logic             Timeout_Err
);

    localparam logic [2:0]  c_flush_reload = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] c_timeout      = 16'(MEM_TIMEOUT);

    hcu_state_t  r_state;
    logic [2:0]  r_flush_cnt;
    logic [15:0] r_wait_cnt;
    logic        r_timeout_err;
    logic        r_lu_stalled;

    logic        w_mem_wait;
    logic        w_load_use;
    logic        w_flush_mode;
    logic        w_lu_stall;
    logic [15:0] w_wait_nxt;

    assign w_mem_wait = DMem_Req && !DMem_Ready;

    assign w_load_use = IDEX_MemRead && (IDEX_Rt != ZERO_REG) &&
                        ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    // A freeze taken mid-flush keeps its counter; the release cycle resumes flushing.
    assign w_flush_mode = (r_state == FLUSH) ||
                          ((r_state == MEM_WAIT) && (r_flush_cnt != 3'd0));

    // r_lu_stalled limits a load-use bubble to one cycle even if ID/EX inputs linger.
    assign w_lu_stall = reset && !w_mem_wait && !Branch_Taken && !w_flush_mode &&
                        w_load_use && !r_lu_stalled;

    assign w_wait_nxt = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Write  = 1'b1;
        IDEX_Flush  = 1'b0;
        Pipe_Freeze = 1'b0;
        if (!reset) begin
            PCWrite    = 1'b0;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (w_mem_wait) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (Branch_Taken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (w_flush_mode) begin
            IFID_Flush = 1'b1;
        end else if (w_lu_stall) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= RUN;
            r_flush_cnt   <= 3'd0;
            r_wait_cnt    <= 16'd0;
            r_timeout_err <= 1'b0;
            r_lu_stalled  <= 1'b0;
        end else begin
            r_lu_stalled <= w_lu_stall;
            if (w_mem_wait) begin
                r_state    <= MEM_WAIT;
                r_wait_cnt <= w_wait_nxt;
                if (w_wait_nxt >= c_timeout) begin
                    r_timeout_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= 16'd0;
                if (Branch_Taken) begin
                    r_flush_cnt <= c_flush_reload;
                    r_state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (w_flush_mode) begin
                    r_flush_cnt <= r_flush_cnt - 3'd1;
                    r_state     <= (r_flush_cnt == 3'd1) ? RUN : FLUSH;
                end else begin
                    r_flush_cnt <= 3'd0;
                    r_state     <= RUN;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .clear_n (reset),
        .inc     (!PCWrite),
        .count   (StallCycles)
    );

    assign Timeout_Err = r_timeout_err;

endmodule

`default_nettype wire
